// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - processor-side store port and memory-side drain port of the store buffer
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic                       MemWrite;
    logic [AW-1:0]              DataAdr;
    logic [DW-1:0]              WriteData;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;
    logic                       mem_valid;
    logic [AW-1:0]              mem_addr;
    logic [DW-1:0]              mem_data;
    logic                       mem_ready;

    modport slave (
        input  MemWrite, DataAdr, WriteData, mem_ready,
        output full, empty, count, overflow, mem_valid, mem_addr, mem_data
    );

    modport master (
        output MemWrite, DataAdr, WriteData, mem_ready,
        input  full, empty, count, overflow, mem_valid, mem_addr, mem_data
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular store FIFO between processor and data memory
// Optional write coalescing into the newest entry: STORE_BUFFER_COALESCE_EN.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic coal;
    logic reject;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign pop   = !empty && sb.mem_ready;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PW-1:0] newest;
    assign newest = tail - 1'b1;
    // A lone entry leaving this edge cannot absorb the store; it becomes a normal push.
    assign coal = sb.MemWrite && !empty && (addr_q[newest] == sb.DataAdr)
                  && !(pop && (cnt == CW'(1)));
`else
    assign coal = 1'b0;
`endif

    // Fullness is judged before any same-edge pop frees a slot.
    assign push   = sb.MemWrite && !full && !coal;
    assign reject = sb.MemWrite && full && !coal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (reject) ovf <= 1'b1;
        end
    end

    // Storage is never cleared; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= sb.DataAdr;
            data_q[tail] <= sb.WriteData;
        end
`ifdef STORE_BUFFER_COALESCE_EN
        else if (coal) begin
            data_q[newest] <= sb.WriteData;
        end
`endif
    end

    assign sb.full      = full;
    assign sb.empty     = empty;
    assign sb.count     = cnt;
    assign sb.overflow  = ovf;
    assign sb.mem_valid = !empty;
    assign sb.mem_addr  = addr_q[head];
    assign sb.mem_data  = data_q[head];
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - vector table plus queue scoreboard for store_buffer
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
`ifdef STORE_BUFFER_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        r;
        int          cnt;
        logic        ovf;
        logic        hd;
        logic [31:0] ha;
        logic [31:0] hdat;
    } vec_t;

    ent_t q[$];
    logic movf;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge reset) begin
        q.delete();
        movf = 1'b0;
    end

    // Reference model: checks outputs, then applies the edge that follows.
    always @(negedge clk) begin
        int   n;
        logic pop;
        logic wasfull;
        logic cl;
        n = q.size();
        if (!reset) begin
            check("rst_count", 64'(bus.count), 64'd0);
            check("rst_valid", 64'(bus.mem_valid), 64'd0);
            check("rst_ovf", 64'(bus.overflow), 64'd0);
        end else begin
            check("mon_count", 64'(bus.count), 64'(n));
            check("mon_empty", 64'(bus.empty), 64'(n == 0));
            check("mon_full", 64'(bus.full), 64'(n == DEPTH));
            check("mon_valid", 64'(bus.mem_valid), 64'(n != 0));
            check("mon_ovf", 64'(bus.overflow), 64'(movf));
            if (n > 0) begin
                check("mon_head_addr", 64'(bus.mem_addr), 64'(q[0].a));
                check("mon_head_data", 64'(bus.mem_data), 64'(q[0].d));
            end
            pop     = (n > 0) && bus.mem_ready;
            wasfull = (n == DEPTH);
            cl      = COAL && bus.MemWrite && (n > 0) && (q[n-1].a == bus.DataAdr)
                      && !(pop && n == 1);
            if (pop) void'(q.pop_front());
            if (cl) q[q.size()-1].d = bus.WriteData;
            else if (bus.MemWrite) begin
                if (!wasfull) q.push_back('{a: bus.DataAdr, d: bus.WriteData});
                else          movf = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
        bus.MemWrite  = w;
        bus.DataAdr   = a;
        bus.WriteData = d;
        bus.mem_ready = r;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        check("pulse_count", 64'(bus.count), 64'd0);
        reset = 1'b1;
    endtask

    task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r,
                       input int cnt, input logic ovf, input logic hd,
                       input logic [31:0] ha, input logic [31:0] hdat);
        tbl.push_back('{w: w, a: a, d: d, r: r, cnt: cnt, ovf: ovf, hd: hd, ha: ha, hdat: hdat});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        movf  = 1'b0;
        reset = 1'b0;
        drive(1'b1, 32'h40, 32'h11, 1'b0);

        // Held in reset with stores offered: nothing may be captured.
        repeat (3) begin
            step();
            check("inreset_count", 64'(bus.count), 64'd0);
            check("inreset_valid", 64'(bus.mem_valid), 64'd0);
            check("inreset_empty", 64'(bus.empty), 64'd1);
        end
        reset = 1'b1;
        step();
        check("first_push_count", 64'(bus.count), 64'd1);
        check("first_push_valid", 64'(bus.mem_valid), 64'd1);
        check("first_push_addr", 64'(bus.mem_addr), 64'h40);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        do_reset();

        add(1, 32'h60, 10, 0, 1, 0, 1, 32'h60, 10);
        add(1, 32'h64, 7,  0, 2, 0, 1, 32'h60, 10);
        add(1, 32'h68, 3,  0, 3, 0, 1, 32'h60, 10);
        add(1, 32'h6C, 1,  0, 4, 0, 1, 32'h60, 10);
        add(1, 32'h70, 9,  0, 4, 1, 1, 32'h60, 10);
        add(0, 32'h0,  0,  1, 3, 1, 1, 32'h64, 7);
        add(0, 32'h0,  0,  1, 2, 1, 1, 32'h68, 3);
        add(0, 32'h0,  0,  1, 1, 1, 1, 32'h6C, 1);
        add(0, 32'h0,  0,  1, 0, 1, 0, 32'h0,  0);
        add(0, 32'h0,  0,  1, 0, 1, 0, 32'h0,  0);
        add(1, 32'h80, 5,  1, 1, 1, 1, 32'h80, 5);
        add(1, 32'h84, 6,  0, 2, 1, 1, 32'h80, 5);
        add(1, 32'h100, 0, 1, 2, 1, 1, 32'h84, 6);
        add(1, 32'h104, 1, 1, 2, 1, 1, 32'h100, 0);
        add(1, 32'h108, 2, 1, 2, 1, 1, 32'h104, 1);
        add(1, 32'h10C, 3, 1, 2, 1, 1, 32'h108, 2);
        add(1, 32'h110, 4, 1, 2, 1, 1, 32'h10C, 3);
        add(1, 32'h114, 5, 1, 2, 1, 1, 32'h110, 4);
        add(1, 32'h200, 32'hA0, 0, 3, 1, 1, 32'h110, 4);
        add(1, 32'h204, 32'hA1, 0, 4, 1, 1, 32'h110, 4);
        add(1, 32'h208, 32'hA2, 1, 3, 1, 1, 32'h114, 5);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].r);
            step();
            check($sformatf("vec%0d_count", i), 64'(bus.count), 64'(tbl[i].cnt));
            check($sformatf("vec%0d_full", i), 64'(bus.full), 64'(tbl[i].cnt == DEPTH));
            check($sformatf("vec%0d_empty", i), 64'(bus.empty), 64'(tbl[i].cnt == 0));
            check($sformatf("vec%0d_ovf", i), 64'(bus.overflow), 64'(tbl[i].ovf));
            if (tbl[i].hd) begin
                check($sformatf("vec%0d_haddr", i), 64'(bus.mem_addr), 64'(tbl[i].ha));
                check($sformatf("vec%0d_hdata", i), 64'(bus.mem_data), 64'(tbl[i].hdat));
            end
        end

        // Same-address back-to-back stores.
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        do_reset();
        drive(1'b1, 32'h64, 32'd5, 1'b0);
        step();
        drive(1'b1, 32'h64, 32'd7, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("coal_count", 64'(bus.count), COAL ? 64'd1 : 64'd2);
        check("coal_head_data", 64'(bus.mem_data), COAL ? 64'd7 : 64'd5);
        check("coal_ovf", 64'(bus.overflow), 64'd0);
        bus.mem_ready = 1'b1;
        begin
            int budget;
            budget = 0;
            while (!bus.empty && budget < 10) begin
                step();
                budget++;
            end
            check("coal_drain_done", 64'(bus.empty), 64'd1);
        end

        // Asynchronous reset mid-cycle with three entries held.
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 32'(i + 20), 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        check("pre_async_count", 64'(bus.count), 64'd3);
        #1 reset = 1'b0;
        #1;
        check("async_count", 64'(bus.count), 64'd0);
        check("async_valid", 64'(bus.mem_valid), 64'd0);
        check("async_empty", 64'(bus.empty), 64'd1);
        check("async_full", 64'(bus.full), 64'd0);
        #1 reset = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (3) begin
            step();
            check("post_async_valid", 64'(bus.mem_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
